// File: rtl/pwm_update_sched_pkg.sv
// Shared constants for the pwm update scheduler: register map, ctrl bits, FSM states.
package pwm_update_sched_pkg;

   localparam logic [2:0] OFF_DUTY_L = 3'd0;
   localparam logic [2:0] OFF_DUTY_H = 3'd1;
   localparam logic [2:0] OFF_FREQ_L = 3'd2;
   localparam logic [2:0] OFF_FREQ_H = 3'd3;
   localparam logic [2:0] OFF_CTRL   = 3'd4;

   localparam int CTRL_COMMIT = 7;
   localparam int CTRL_EN     = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      APPLY = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_update_sched_if.sv
// Host write bus, period boundary pulses and per-channel pwm control outputs.
interface pwm_update_sched_if #(
   parameter int NCH = 4
) ();
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic              wr_en;
   logic [CW+2:0]     wr_addr;
   logic [7:0]        wr_data;
   logic [NCH-1:0]    period_start;
   logic [16*NCH-1:0] pwm_duty;
   logic [16*NCH-1:0] pwm_freq;
   logic [NCH-1:0]    pwm_enb;
   logic [NCH-1:0]    commit_done;
   logic [NCH-1:0]    slewing;

   modport master (
      output wr_en, wr_addr, wr_data, period_start,
      input  pwm_duty, pwm_freq, pwm_enb, commit_done, slewing
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, period_start,
      output pwm_duty, pwm_freq, pwm_enb, commit_done, slewing
   );
endinterface

// File: rtl/pwm_update_sched_arb.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping around.
module pwm_rr_arb #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          valid_o
);
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   // Walk the channels starting at ptr and keep only the first request found.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!valid_o && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/pwm_update_sched.sv
// Per-channel shadow registers with boundary-aligned commit and a shared duty slew unit.
module pwm_update_sched
   import pwm_update_sched_pkg::*;
#(
   parameter int          NCH      = 4,
   parameter logic [15:0] STEP_MAX = 16'h0040
) (
   input logic              clk,
   input logic              reset,
   pwm_update_sched_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [15:0]    sh_duty_q [NCH];
   logic [15:0]    sh_freq_q [NCH];
   logic [NCH-1:0] sh_en_q;
   logic [15:0]    duty_q [NCH];
   logic [15:0]    freq_q [NCH];
   logic [15:0]    tgt_q  [NCH];
   logic [NCH-1:0] enb_q, pend_q, evt_q, done_q;
   logic [NCH-1:0] pend_d, evt_d;
   state_t         state_q;
   logic [CW-1:0]  ptr_q, g_q, gidx;
   logic           commit_q, nen_q;
   logic [15:0]    nduty_q, ntgt_q, nfreq_q;

   logic [CW-1:0]  wch;
   logic [2:0]     woff;
   logic           wvalid;
   logic [NCH-1:0] cw_oh, apply_oh, clr_pend, slew_w, req, gnt_oh;
   logic           gnt_vld;
   logic           c_pend, c_en;
   logic [15:0]    c_tgt, c_duty;

   // One slew step toward tgt; sums are 17 bits so neither direction can wrap.
   function automatic logic [15:0] slew_next(input logic [15:0] cur, input logic [15:0] tgt);
      logic [16:0] lim;
      if (STEP_MAX == 16'h0) return tgt;
      if (tgt > cur) begin
         lim = {1'b0, cur} + {1'b0, STEP_MAX};
         return (lim > {1'b0, tgt}) ? tgt : lim[15:0];
      end
      lim = {1'b0, tgt} + {1'b0, STEP_MAX};
      return ({1'b0, cur} < lim) ? tgt : (cur - STEP_MAX);
   endfunction

   assign wch    = bus.wr_addr[CW+2:3];
   assign woff   = bus.wr_addr[2:0];
   assign wvalid = bus.wr_en && (int'(wch) < NCH);

   // Per-channel decode of commit writes, the channel in APPLY, and request formation.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         cw_oh[i]    = wvalid && (woff == OFF_CTRL) && bus.wr_data[CTRL_COMMIT] && (int'(wch) == i);
         apply_oh[i] = (state_q == APPLY) && (int'(g_q) == i);
         slew_w[i]   = (duty_q[i] != tgt_q[i]);
      end
      clr_pend = apply_oh & {NCH{commit_q}};
      req      = evt_q & (pend_q | slew_w);
      // A commit write landing in its own APPLY cycle survives the clear.
      pend_d   = (pend_q & ~clr_pend) | cw_oh;
      // The channel being committed does not re-arm itself from its own pending bit.
      evt_d    = (evt_q & req & ~apply_oh) | bus.period_start | (pend_q & ~enb_q & ~clr_pend);
   end

   // Grant index from the arbiter's one-hot output.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NCH; i++) if (gnt_oh[i]) gidx = CW'(i);
   end

   // Values the APPLY step will write, computed for the latched grant.
   always_comb begin
      c_pend = pend_q[g_q];
      c_en   = sh_en_q[g_q];
      c_tgt  = c_pend ? (c_en ? sh_duty_q[g_q] : 16'h0) : tgt_q[g_q];
      c_duty = (c_pend && !c_en) ? 16'h0 : slew_next(duty_q[g_q], c_tgt);
   end

   pwm_rr_arb #(.N(NCH), .PW(CW)) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (gnt_oh),
      .valid_o (gnt_vld)
   );

   // Host byte writes into the shadow registers; last write before a commit wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            sh_duty_q[i] <= '0;
            sh_freq_q[i] <= '0;
         end
         sh_en_q <= '0;
      end else if (wvalid) begin
         case (woff)
            OFF_DUTY_L: sh_duty_q[wch][7:0]  <= bus.wr_data;
            OFF_DUTY_H: sh_duty_q[wch][15:8] <= bus.wr_data;
            OFF_FREQ_L: sh_freq_q[wch][7:0]  <= bus.wr_data;
            OFF_FREQ_H: sh_freq_q[wch][15:8] <= bus.wr_data;
            OFF_CTRL:   sh_en_q[wch]         <= bus.wr_data[CTRL_EN];
            default: ;
         endcase
      end
   end

   // Pending commits and boundary event latches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         evt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         evt_q  <= evt_d;
      end
   end

   // Service FSM: pick a channel, compute its update, then write the active registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         g_q      <= '0;
         commit_q <= 1'b0;
         nen_q    <= 1'b0;
         nduty_q  <= '0;
         ntgt_q   <= '0;
         nfreq_q  <= '0;
         enb_q    <= '0;
         done_q   <= '0;
         for (int i = 0; i < NCH; i++) begin
            duty_q[i] <= '0;
            freq_q[i] <= '0;
            tgt_q[i]  <= '0;
         end
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  g_q     <= gidx;
                  state_q <= CALC;
               end
            end
            CALC: begin
               commit_q <= c_pend;
               nduty_q  <= c_duty;
               ntgt_q   <= c_tgt;
               nfreq_q  <= sh_freq_q[g_q];
               nen_q    <= c_en;
               state_q  <= APPLY;
            end
            APPLY: begin
               duty_q[g_q] <= nduty_q;
               tgt_q[g_q]  <= ntgt_q;
               if (commit_q) begin
                  freq_q[g_q] <= nfreq_q;
                  enb_q[g_q]  <= nen_q;
                  done_q[g_q] <= 1'b1;
               end
               ptr_q   <= (int'(g_q) == NCH-1) ? '0 : g_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Flatten the active registers onto the pwm-facing buses.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         bus.pwm_duty[16*i +: 16] = duty_q[i];
         bus.pwm_freq[16*i +: 16] = freq_q[i];
      end
      bus.pwm_enb     = enb_q;
      bus.commit_done = done_q;
      bus.slewing     = slew_w;
   end
endmodule

// File: tb/tb_pwm_update_sched.sv
// Bench for pwm_update_sched: directed scenarios plus randomized traffic against a channel model.
module tb_pwm_update_sched;
   localparam int NCH  = 4;
   localparam int STEP = 'h40;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   pwm_update_sched_if #(.NCH(NCH)) bus ();

   pwm_update_sched #(.NCH(NCH), .STEP_MAX(16'h0040)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic int gd(input int c);
      return int'(bus.pwm_duty[16*c +: 16]);
   endfunction

   function automatic int gf(input int c);
      return int'(bus.pwm_freq[16*c +: 16]);
   endfunction

   task automatic wr(input int c, input int off, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = {2'(c), 3'(off)};
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] m);
      @(negedge clk);
      bus.period_start = m;
      @(negedge clk);
      bus.period_start = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   int m_sd[NCH], m_sf[NCH], m_se[NCH], m_pend[NCH];
   int m_duty[NCH], m_tgt[NCH], m_freq[NCH], m_enb[NCH], m_done[NCH];

   function automatic int step_to(input int cur, input int tgt);
      if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
      return (cur - STEP > tgt) ? cur - STEP : tgt;
   endfunction

   task automatic m_serve(input int c);
      if (m_pend[c] != 0) begin
         m_freq[c] = m_sf[c];
         m_enb[c]  = m_se[c];
         m_tgt[c]  = (m_se[c] != 0) ? m_sd[c] : 0;
         m_duty[c] = (m_se[c] != 0) ? step_to(m_duty[c], m_tgt[c]) : 0;
         m_pend[c] = 0;
         m_done[c]++;
      end else begin
         m_duty[c] = step_to(m_duty[c], m_tgt[c]);
      end
   endtask

   task automatic m_write(input int c, input int off, input int d);
      case (off)
         0: m_sd[c] = (m_sd[c] & 'hFF00) | d;
         1: m_sd[c] = (m_sd[c] & 'h00FF) | (d << 8);
         2: m_sf[c] = (m_sf[c] & 'hFF00) | d;
         3: m_sf[c] = (m_sf[c] & 'h00FF) | (d << 8);
         4: begin
            m_se[c] = d & 1;
            if (d >= 'h80) m_pend[c] = 1;
         end
         default: ;
      endcase
      if (m_pend[c] != 0 && m_enb[c] == 0) m_serve(c);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.pwm_duty !== '0) begin bad++; $display("FAIL rst_duty got=%h want=0", bus.pwm_duty); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (bus.pwm_duty !== '0) begin bad++; $display("FAIL rst_duty_rel got=%h want=0", bus.pwm_duty); end
      total++; if (bus.pwm_freq !== '0) begin bad++; $display("FAIL rst_freq got=%h want=0", bus.pwm_freq); end
      total++; if (bus.pwm_enb !== '0) begin bad++; $display("FAIL rst_enb got=%h want=0", bus.pwm_enb); end
      total++; if (bus.commit_done !== '0) begin bad++; $display("FAIL rst_done got=%h want=0", bus.commit_done); end
      total++; if (bus.slewing !== '0) begin bad++; $display("FAIL rst_slew got=%h want=0", bus.slewing); end
   endtask

   task automatic test_immediate_commit();
      int found = -1;
      wr(0, 0, 8'h00); wr(0, 1, 8'h80); wr(0, 2, 8'hE8); wr(0, 3, 8'h03); wr(0, 4, 8'h81);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.commit_done[0] === 1'b1 && found < 0) found = k;
      end
      total++; if (found < 0 || found > 4) begin bad++; $display("FAIL imm_done_lat got=%0d want=0..4", found); end
      total++; if (bus.pwm_enb[0] !== 1'b1) begin bad++; $display("FAIL imm_enb got=%b want=1", bus.pwm_enb[0]); end
      total++; if (gf(0) != 'h03E8) begin bad++; $display("FAIL imm_freq got=%h want=03e8", gf(0)); end
      total++; if (gd(0) != 'h0040) begin bad++; $display("FAIL imm_duty got=%h want=0040", gd(0)); end
      total++; if (bus.slewing[0] !== 1'b1) begin bad++; $display("FAIL imm_slew got=%b want=1", bus.slewing[0]); end
   endtask

   task automatic test_slew_up();
      int exp_up[4] = '{'h40, 'h80, 'hC0, 'h100};
      int nd;
      wr(0, 4, 8'h80); pulse(4'h1); idle(8);
      total++; if (gd(0) != 0 || bus.pwm_enb[0] !== 1'b0) begin bad++; $display("FAIL su_disable got=%h/%b want=0/0", gd(0), bus.pwm_enb[0]); end
      wr(0, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 4, 8'h81); idle(8);
      total++; if (bus.pwm_enb[0] !== 1'b1) begin bad++; $display("FAIL su_enable got=%b want=1", bus.pwm_enb[0]); end
      wr(0, 1, 8'h01); wr(0, 4, 8'h81); idle(8);
      total++; if (gd(0) != 0) begin bad++; $display("FAIL su_wait got=%h want=0", gd(0)); end
      for (int k = 0; k < 4; k++) begin
         pulse(4'h1); idle(6);
         total++; if (gd(0) != exp_up[k]) begin bad++; $display("FAIL su_step%0d got=%h want=%h", k, gd(0), exp_up[k]); end
         total++; if (bus.slewing[0] !== (k < 3)) begin bad++; $display("FAIL su_slew%0d got=%b want=%b", k, bus.slewing[0], (k < 3)); end
      end
      nd = 0;
      pulse(4'h1);
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (bus.commit_done[0] === 1'b1) nd++; end
      total++; if (gd(0) != 'h100 || nd != 0) begin bad++; $display("FAIL su_fifth got=%h/%0d want=0100/0", gd(0), nd); end
   endtask

   task automatic test_burst_order();
      int order[$];
      int tms[$];
      int exp0[2] = '{'hC0, 'h80};
      for (int c = 1; c < NCH; c++) begin wr(c, 4, 8'h81); idle(8); end
      for (int b = 0; b < 2; b++) begin
         order.delete(); tms.delete();
         for (int c = 0; c < NCH; c++) begin
            wr(c, 0, 8'((c + 1) * 16)); wr(c, 1, 8'h00); wr(c, 4, 8'h81);
         end
         pulse(4'hF);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) if (bus.commit_done[c] === 1'b1) begin order.push_back(c); tms.push_back(cyc); end
         end
         total++;
         if (order.size() != NCH) begin
            bad++; $display("FAIL burst%0d_count got=%0d want=%0d", b, order.size(), NCH);
         end else begin
            for (int i = 0; i < NCH; i++) begin
               total++; if (order[i] != i) begin bad++; $display("FAIL burst%0d_order%0d got=%0d want=%0d", b, i, order[i], i); end
               if (i > 0) begin
                  total++; if (tms[i] - tms[i-1] != 3) begin bad++; $display("FAIL burst%0d_gap%0d got=%0d want=3", b, i, tms[i] - tms[i-1]); end
               end
            end
         end
         total++; if (gd(0) != exp0[b]) begin bad++; $display("FAIL burst%0d_duty0 got=%h want=%h", b, gd(0), exp0[b]); end
         for (int c = 1; c < NCH; c++) begin
            total++; if (gd(c) != (c + 1) * 16) begin bad++; $display("FAIL burst%0d_duty%0d got=%h want=%h", b, c, gd(c), (c + 1) * 16); end
         end
      end
   endtask

   task automatic test_apply_race();
      int nd;
      wr(0, 0, 8'h00); wr(0, 1, 8'h10); wr(0, 1, 8'h20); wr(0, 4, 8'h81);
      pulse(4'h1);
      @(negedge clk);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = {2'd0, 3'd4}; bus.wr_data = 8'h81;
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.commit_done[0] !== 1'b1) begin bad++; $display("FAIL race_done got=%b want=1", bus.commit_done[0]); end
      total++; if (gd(0) != 'hC0) begin bad++; $display("FAIL race_duty got=%h want=00c0", gd(0)); end
      idle(8);
      total++; if (gd(0) != 'hC0) begin bad++; $display("FAIL race_hold got=%h want=00c0", gd(0)); end
      for (int p = 0; p < 2; p++) begin
         nd = 0;
         pulse(4'h1);
         for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.commit_done[0] === 1'b1) nd++; end
         total++; if (nd != 1 - p) begin bad++; $display("FAIL race_pend%0d got=%0d want=%0d", p, nd, 1 - p); end
         total++; if (gd(0) != 'h100 + p * 'h40) begin bad++; $display("FAIL race_duty%0d got=%h want=%h", p, gd(0), 'h100 + p * 'h40); end
      end
   endtask

   task automatic test_down_slew();
      wr(2, 0, 8'h00); wr(2, 4, 8'h81); pulse(4'h4); idle(8);
      total++; if (gd(2) != 0) begin bad++; $display("FAIL down_duty got=%h want=0", gd(2)); end
      total++; if (bus.slewing[2] !== 1'b0) begin bad++; $display("FAIL down_slew got=%b want=0", bus.slewing[2]); end
      wr(3, 2, 8'h34); wr(3, 3, 8'h12); wr(3, 4, 8'h80); pulse(4'h8); idle(8);
      total++; if (gd(3) != 0 || bus.pwm_enb[3] !== 1'b0 || bus.slewing[3] !== 1'b0) begin
         bad++; $display("FAIL dis_clear got=%h/%b/%b want=0/0/0", gd(3), bus.pwm_enb[3], bus.slewing[3]);
      end
      total++; if (gf(3) != 'h1234) begin bad++; $display("FAIL dis_freq got=%h want=1234", gf(3)); end
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      wr(1, 4, 8'h81);
      @(negedge clk); bus.period_start = 4'h1;
      @(negedge clk); bus.period_start = '0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      total++; if (bus.pwm_duty !== '0 || bus.pwm_freq !== '0 || bus.pwm_enb !== '0) begin
         bad++; $display("FAIL mid_rst got=%h/%h/%h want=0", bus.pwm_duty, bus.pwm_freq, bus.pwm_enb);
      end
      reset = 1'b0;
      pulse(4'h2);
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.commit_done !== '0) nd++; end
      total++; if (nd != 0 || bus.pwm_duty !== '0) begin bad++; $display("FAIL mid_lost got=%0d/%h want=0/0", nd, bus.pwm_duty); end
   endtask

   task automatic test_random();
      int got[NCH];
      int c, off, d;
      logic [3:0] m;
      for (int i = 0; i < NCH; i++) begin
         m_sd[i] = 0; m_sf[i] = 0; m_se[i] = 0; m_pend[i] = 0;
         m_duty[i] = 0; m_tgt[i] = 0; m_freq[i] = 0; m_enb[i] = 0;
      end
      for (int op = 0; op < 60; op++) begin
         for (int i = 0; i < NCH; i++) begin m_done[i] = 0; got[i] = 0; end
         if ($urandom_range(0, 9) < 4) begin
            m = 4'($urandom_range(1, 15));
            pulse(m);
            for (int i = 0; i < NCH; i++) if (m[i] && (m_pend[i] != 0 || m_duty[i] != m_tgt[i])) m_serve(i);
         end else begin
            c   = $urandom_range(0, NCH - 1);
            off = ($urandom_range(0, 2) == 0) ? 4 : $urandom_range(0, 7);
            d   = $urandom_range(0, 255);
            wr(c, off, 8'(d));
            m_write(c, off, d);
         end
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (bus.commit_done[i] === 1'b1) got[i]++;
         end
         for (int i = 0; i < NCH; i++) begin
            total++; if (gd(i) != m_duty[i]) begin bad++; $display("FAIL rnd%0d_duty%0d got=%h want=%h", op, i, gd(i), m_duty[i]); end
            total++; if (gf(i) != m_freq[i]) begin bad++; $display("FAIL rnd%0d_freq%0d got=%h want=%h", op, i, gf(i), m_freq[i]); end
            total++; if (bus.pwm_enb[i] !== 1'(m_enb[i])) begin bad++; $display("FAIL rnd%0d_enb%0d got=%b want=%0d", op, i, bus.pwm_enb[i], m_enb[i]); end
            total++; if (bus.slewing[i] !== (m_duty[i] != m_tgt[i])) begin bad++; $display("FAIL rnd%0d_slew%0d got=%b want=%b", op, i, bus.slewing[i], (m_duty[i] != m_tgt[i])); end
            total++; if (got[i] != m_done[i]) begin bad++; $display("FAIL rnd%0d_done%0d got=%0d want=%0d", op, i, got[i], m_done[i]); end
         end
      end
   endtask

   initial begin
      bus.wr_en        = 1'b0;
      bus.wr_addr      = '0;
      bus.wr_data      = '0;
      bus.period_start = '0;
      test_reset();
      test_immediate_commit();
      test_slew_up();
      test_burst_order();
      test_apply_race();
      test_down_slew();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
